// File: rtl/da_shift_accumulator_if.sv
// Bundle of the start/sample request, coefficient-ROM port and result signals
// of the distributed-arithmetic shift-accumulate engine.
interface da_shift_accumulator_if #(
    parameter int IN_W  = 8,
    parameter int ROM_W = 15,
    parameter int ACC_W = 24
);
    logic                    start;
    logic signed [IN_W-1:0]  x0, x1, x2, x3;
    logic [3:0]              rom_addr;
    logic signed [ROM_W-1:0] rom_q0, rom_q1, rom_q2, rom_q3;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] y0, y1, y2, y3;

    // Requester side: issues samples, supplies ROM words, consumes results.
    modport master (
        output start, x0, x1, x2, x3, rom_q0, rom_q1, rom_q2, rom_q3,
        input  rom_addr, busy, done, y0, y1, y2, y3
    );

    // Engine side.
    modport slave (
        input  start, x0, x1, x2, x3, rom_q0, rom_q1, rom_q2, rom_q3,
        output rom_addr, busy, done, y0, y1, y2, y3
    );
endinterface

// File: rtl/da_shift_accumulator.sv
// Distributed-arithmetic shift-accumulate engine. Four latched samples are
// scanned MSB first; each cycle the bit slice addresses the coefficient ROM
// and the four ROM words are folded into four signed accumulators. The sign
// bit slice is subtracted, all later slices are added after a doubling.
module da_shift_accumulator #(
    parameter int IN_W  = 8,
    parameter int ROM_W = 15,
    parameter int ACC_W = 24
) (
    input logic                  clk,
    input logic                  rst,
    da_shift_accumulator_if.slave bus
);
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_next;
    logic [IN_W-1:0]         sr       [4];
    logic signed [ROM_W-1:0] rom_q    [4];
    logic signed [ACC_W-1:0] rom_ext  [4];
    logic signed [ACC_W-1:0] acc      [4];
    logic signed [ACC_W-1:0] acc_next [4];
    logic signed [ACC_W-1:0] y        [4];
    logic [CNT_W-1:0]        cnt;
    logic                    done_q;
    logic                    load;
    logic                    first;
    logic                    last;

    assign rom_q[0] = bus.rom_q0;
    assign rom_q[1] = bus.rom_q1;
    assign rom_q[2] = bus.rom_q2;
    assign rom_q[3] = bus.rom_q3;

    assign bus.rom_addr = {sr[3][IN_W-1], sr[2][IN_W-1], sr[1][IN_W-1], sr[0][IN_W-1]};
    assign bus.busy     = (state == RUN);
    assign bus.done     = done_q;
    assign bus.y0       = y[0];
    assign bus.y1       = y[1];
    assign bus.y2       = y[2];
    assign bus.y3       = y[3];

    assign load  = (state == IDLE) && bus.start;
    assign first = (state == RUN) && (cnt == CNT_LAST);
    assign last  = (state == RUN) && (cnt == '0);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: accept start only in IDLE, leave RUN after bit 0.
    // NOTE: the default assignment first guarantees no latch is inferred
    // on paths the case statement does not cover.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accumulator update: negate the sign-bit slice, double-and-add the rest.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rom_ext[k]  = {{(ACC_W-ROM_W){rom_q[k][ROM_W-1]}}, rom_q[k]};
            acc_next[k] = first ? -rom_ext[k] : ((acc[k] <<< 1) + rom_ext[k]);
        end
    end

    // Datapath: sample latch and shift, accumulation, result capture, done pulse.
    // NOTE: the small register arrays here are reset explicitly because an
    // aborted run must leave results and scan state cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                sr[k]  <= '0;
                acc[k] <= '0;
                y[k]   <= '0;
            end
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                sr[0] <= bus.x0;
                sr[1] <= bus.x1;
                sr[2] <= bus.x2;
                sr[3] <= bus.x3;
                for (int k = 0; k < 4; k++) acc[k] <= '0;
                cnt <= CNT_LAST;
            end else if (state == RUN) begin
                for (int k = 0; k < 4; k++) begin
                    sr[k]  <= sr[k] << 1;
                    acc[k] <= acc_next[k];
                end
                cnt <= cnt - 1'b1;
                if (last) begin
                    for (int k = 0; k < 4; k++) y[k] <= acc_next[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_da_shift_accumulator.sv
// Directed bench for da_shift_accumulator with a behavioural coefficient ROM.
// The ROM word for output k at address A is the sum of c[k][i] over the set
// bits i of A, so every result is the plain dot product sum_i x_i * c[k][i].
module tb_da_shift_accumulator;
    localparam int IN_W  = 8;
    localparam int ROM_W = 15;
    localparam int ACC_W = 24;

    logic clk;
    logic rst;
    int   n_total  = 0;
    int   n_passed = 0;
    int   done_cnt = 0;
    int   xv [4];
    int   lat;
    int   dones_seen;

    // Odd-stage coefficients (Q10), row k = output, column i = sample x_i.
    int coef [4][4] = '{
        '{  199,   569,   852,  1004},
        '{ -568, -1004,  -199,   851},
        '{  851,   199, -1004,   569},
        '{-1004,   851,  -568,   199}
    };

    da_shift_accumulator_if #(.IN_W(IN_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) bus ();

    da_shift_accumulator #(.IN_W(IN_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [ROM_W-1:0] rom_word(int k, logic [3:0] a);
        int s = 0;
        for (int i = 0; i < 4; i++) if (a[i]) s += coef[k][i];
        return ROM_W'(s);
    endfunction

    always_comb begin
        bus.rom_q0 = rom_word(0, bus.rom_addr);
        bus.rom_q1 = rom_word(1, bus.rom_addr);
        bus.rom_q2 = rom_word(2, bus.rom_addr);
        bus.rom_q3 = rom_word(3, bus.rom_addr);
    end

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    function automatic longint y_ref(int k);
        longint s = 0;
        for (int i = 0; i < 4; i++) s += longint'(xv[i]) * longint'(coef[k][i]);
        return s;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x();
        bus.x0 = IN_W'(xv[0]);
        bus.x1 = IN_W'(xv[1]);
        bus.x2 = IN_W'(xv[2]);
        bus.x3 = IN_W'(xv[3]);
    endtask

    // Start a transform with xv and wait (bounded) for done.
    task automatic run_xform(output int l);
        set_x();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        l = 0;
        while (bus.done !== 1'b1 && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_y0"}, longint'(bus.y0), y_ref(0));
        check({tag, "_y1"}, longint'(bus.y1), y_ref(1));
        check({tag, "_y2"}, longint'(bus.y2), y_ref(2));
        check({tag, "_y3"}, longint'(bus.y3), y_ref(3));
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        xv        = '{0, 0, 0, 0};
        set_x();
        tick();
        tick();

        // Reset state
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_addr", longint'(bus.rom_addr), 0);
        check("rst_y0", longint'(bus.y0), 0);
        check("rst_y1", longint'(bus.y1), 0);
        check("rst_y2", longint'(bus.y2), 0);
        check("rst_y3", longint'(bus.y3), 0);
        rst = 1'b0;
        tick();

        // x0 = 1: address stays 0 until the LSB slice, result = column 0
        xv = '{1, 0, 0, 0};
        set_x();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("unit_addr_c%0d", c), longint'(bus.rom_addr), (c == 8) ? 1 : 0);
            check($sformatf("unit_busy_c%0d", c), longint'(bus.busy), 1);
            check($sformatf("unit_done_c%0d", c), longint'(bus.done), 0);
            tick();
        end
        check("unit_done", longint'(bus.done), 1);
        check("unit_busy_off", longint'(bus.busy), 0);
        check("unit_y0", longint'(bus.y0), 199);
        check("unit_y1", longint'(bus.y1), -568);
        check("unit_y2", longint'(bus.y2), 851);
        check("unit_y3", longint'(bus.y3), -1004);
        tick();
        check("unit_done_pulse", longint'(bus.done), 0);
        check("unit_y0_hold", longint'(bus.y0), 199);

        // x0 = -128: sign slice only
        xv = '{-128, 0, 0, 0};
        run_xform(lat);
        check("neg_lat", longint'(lat), 8);
        check("neg_y0", longint'(bus.y0), -25472);
        check("neg_y1", longint'(bus.y1), 72704);
        check("neg_y2", longint'(bus.y2), -108928);
        check("neg_y3", longint'(bus.y3), 128512);
        tick();

        // Full-scale positive
        xv = '{127, 127, 127, 127};
        run_xform(lat);
        check("pos_lat", longint'(lat), 8);
        check("pos_y0", longint'(bus.y0), 333248);
        check_model("pos");
        tick();

        // Full-scale negative
        xv = '{-128, -128, -128, -128};
        run_xform(lat);
        check("fneg_y0", longint'(bus.y0), -335872);
        check_model("fneg");
        tick();

        // All zeros
        xv = '{0, 0, 0, 0};
        run_xform(lat);
        check("zero_lat", longint'(lat), 8);
        check("zero_y0", longint'(bus.y0), 0);
        check("zero_y1", longint'(bus.y1), 0);
        check("zero_y2", longint'(bus.y2), 0);
        check("zero_y3", longint'(bus.y3), 0);
        tick();

        // Start while busy is ignored; start in the done cycle is accepted
        xv = '{37, -90, 5, 120};
        set_x();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        for (int c = 2; c <= 7; c++) begin
            bus.x0 = 8'sd99;
            bus.x1 = 8'sd99;
            bus.x2 = -8'sd99;
            bus.x3 = 8'sd1;
            bus.start = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        check("ign_busy_c8", longint'(bus.busy), 1);
        tick();
        check("ign_done", longint'(bus.done), 1);
        check_model("ign");
        xv = '{-1, 64, -77, 3};
        run_xform(lat);
        check("b2b_lat", longint'(lat), 8);
        check("b2b_done", longint'(bus.done), 1);
        check_model("b2b");
        tick();

        // Reset during RUN aborts with no done
        xv = '{50, 60, 70, 80};
        set_x();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_y0", longint'(bus.y0), 0);
        check("abort_y3", longint'(bus.y3), 0);
        check("abort_done", longint'(bus.done), 0);
        dones_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done === 1'b1) dones_seen++;
            tick();
        end
        check("abort_no_done", longint'(dones_seen), 0);

        // Reset wins over start
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_prio_busy", longint'(bus.busy), 0);

        // Fresh run after abort
        xv = '{-100, 33, 12, -7};
        run_xform(lat);
        check("fresh_lat", longint'(lat), 8);
        check_model("fresh");
        tick();

        // Random transforms with random idle gaps
        dones_seen = done_cnt;
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < 4; i++) xv[i] = int'($signed(8'($urandom)));
            run_xform(lat);
            check($sformatf("rnd%0d_lat", t), longint'(lat), 8);
            check_model($sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();
        check("rnd_done_count", longint'(done_cnt - dones_seen), 1000);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
